// File: rtl/tri_raster_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// types_pkg
//   Shared types and helpers for the triangle rasteriser.
//   - WIDTH      : bit width of a signed vertex coordinate
//   - EDGE_W     : full-precision width of an edge-function result
//   - vector_t   : signed (x,y) vertex
//   - diff_t     : signed (x,y) difference of two vertices (one extra bit)
//   - rast_state_t : rasteriser FSM states
//   - cross_prod : exact 2D cross product of two difference vectors
//   - min3/max3  : signed three-way min/max used for the bounding box
// -----------------------------------------------------------------------------
package types_pkg;

    localparam int WIDTH  = 12;
    localparam int DIFF_W = WIDTH + 1;
    localparam int PROD_W = 2 * WIDTH + 2;
    localparam int EDGE_W = 2 * WIDTH + 3;

    typedef struct packed {
        logic signed [WIDTH-1:0] x;
        logic signed [WIDTH-1:0] y;
    } vector_t;

    typedef struct packed {
        logic signed [DIFF_W-1:0] x;
        logic signed [DIFF_W-1:0] y;
    } diff_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SCAN  = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } rast_state_t;

    // a.x*b.y - a.y*b.x. Operands are sign-extended before multiplying so the
    // products and the difference are exact; nothing is ever truncated.
    function automatic logic signed [EDGE_W-1:0] cross_prod(input diff_t a, input diff_t b);
        logic signed [PROD_W-1:0] p0;
        logic signed [PROD_W-1:0] p1;
        p0 = PROD_W'(a.x) * PROD_W'(b.y);
        p1 = PROD_W'(a.y) * PROD_W'(b.x);
        return EDGE_W'(p0) - EDGE_W'(p1);
    endfunction

    function automatic logic signed [WIDTH-1:0] min3(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b,
                                                     input logic signed [WIDTH-1:0] c);
        logic signed [WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic signed [WIDTH-1:0] max3(input logic signed [WIDTH-1:0] a,
                                                     input logic signed [WIDTH-1:0] b,
                                                     input logic signed [WIDTH-1:0] c);
        logic signed [WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_raster_ctrl_edge_eval.sv
// -----------------------------------------------------------------------------
// edge_eval
//   Combinational edge function E(a,b,p) = (b.x-a.x)(p.y-a.y) - (b.y-a.y)(p.x-a.x)
//   at full precision.
//   Ports:
//     i_a, i_b : edge end points
//     i_p      : point under test
//     o_e      : signed edge value (EDGE_W bits)
// -----------------------------------------------------------------------------
module edge_eval
    import types_pkg::*;
(
    input  vector_t                  i_a,
    input  vector_t                  i_b,
    input  vector_t                  i_p,
    output logic signed [EDGE_W-1:0] o_e
);

    diff_t w_ab;
    diff_t w_ap;

    always_comb begin
        w_ab.x = DIFF_W'(i_b.x) - DIFF_W'(i_a.x);
        w_ab.y = DIFF_W'(i_b.y) - DIFF_W'(i_a.y);
        w_ap.x = DIFF_W'(i_p.x) - DIFF_W'(i_a.x);
        w_ap.y = DIFF_W'(i_p.y) - DIFF_W'(i_a.y);
        o_e    = cross_prod(w_ab, w_ap);
    end

endmodule

// File: rtl/tri_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tri_raster_ctrl
//   Accepts one triangle, computes its screen-clipped bounding box and walks
//   it in raster order, evaluating the three edge functions one per cycle on a
//   single shared evaluator. Covered pixels are offered downstream.
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high. The producer holds valid and its payload stable until that
//   edge; ready may be asserted independently of valid.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     tri_valid/ready   triangle input handshake (ready only in IDLE)
//     v0, v1, v2        signed vertices, sampled on the triangle handshake
//     abort             cancel the current triangle (no done pulse)
//     px_valid/ready    covered-pixel output handshake
//     px_x, px_y        unsigned pixel coordinates
//     busy              high whenever not IDLE
//     done              one-cycle pulse when a triangle completes
// -----------------------------------------------------------------------------
module tri_raster_ctrl
    import types_pkg::*;
#(
    parameter int H_RES = 320,
    parameter int V_RES = 240
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tri_valid,
    output logic             tri_ready,
    input  vector_t          v0,
    input  vector_t          v1,
    input  vector_t          v2,
    input  logic             abort,
    output logic             px_valid,
    input  logic             px_ready,
    output logic [WIDTH-2:0] px_x,
    output logic [WIDTH-2:0] px_y,
    output logic             busy,
    output logic             done
);

    localparam logic signed [WIDTH:0] LP_XLIM  = (WIDTH+1)'(H_RES);
    localparam logic signed [WIDTH:0] LP_YLIM  = (WIDTH+1)'(V_RES);
    localparam logic [WIDTH-2:0]      LP_XLAST = (WIDTH-1)'(H_RES - 1);
    localparam logic [WIDTH-2:0]      LP_YLAST = (WIDTH-1)'(V_RES - 1);

    rast_state_t      r_state;
    rast_state_t      w_next_state;
    vector_t          r_v0, r_v1, r_v2;
    logic [WIDTH-2:0] r_x, r_y, r_xmin, r_xmax, r_ymax;
    logic [WIDTH-2:0] w_x, w_y, w_xmin, w_xmax, w_ymax;
    logic [1:0]       r_phase, w_phase;
    logic [1:0]       r_ge, r_le, w_ge, w_le;
    logic             r_tri_ready, r_px_valid, r_busy, r_done;
    logic             w_adv;

    // ---------------- shared edge evaluator ----------------
    vector_t                  w_ea, w_eb, w_ep, w_pt;
    logic signed [EDGE_W-1:0] w_e;
    logic                     w_e_ge, w_e_le;

    // SETUP evaluates the doubled area E(v0,v1,v2); SCAN phases pick an edge.
    always_comb begin
        w_pt.x = {1'b0, r_x};
        w_pt.y = {1'b0, r_y};
        w_ea   = r_v0;
        w_eb   = r_v1;
        w_ep   = r_v2;
        if (r_state == ST_SCAN) begin
            case (r_phase)
                2'd0:    begin w_ea = r_v0; w_eb = r_v1; w_ep = w_pt; end
                2'd1:    begin w_ea = r_v1; w_eb = r_v2; w_ep = w_pt; end
                default: begin w_ea = r_v2; w_eb = r_v0; w_ep = w_pt; end
            endcase
        end
    end

    edge_eval u_edge_eval (
        .i_a (w_ea),
        .i_b (w_eb),
        .i_p (w_ep),
        .o_e (w_e)
    );

    assign w_e_ge = ~w_e[EDGE_W-1];
    assign w_e_le = w_e[EDGE_W-1] | (w_e == '0);

    // ---------------- bounding box ----------------
    // One extra bit so the screen limits compare as signed values.
    logic signed [WIDTH:0] w_xlo, w_xhi, w_ylo, w_yhi;
    logic [WIDTH-2:0]      w_cxmin, w_cxmax, w_cymin, w_cymax;
    logic                  w_bbox_empty;

    assign w_xlo = (WIDTH+1)'(min3(r_v0.x, r_v1.x, r_v2.x));
    assign w_xhi = (WIDTH+1)'(max3(r_v0.x, r_v1.x, r_v2.x));
    assign w_ylo = (WIDTH+1)'(min3(r_v0.y, r_v1.y, r_v2.y));
    assign w_yhi = (WIDTH+1)'(max3(r_v0.y, r_v1.y, r_v2.y));

    assign w_bbox_empty = w_xhi[WIDTH] | w_yhi[WIDTH] |
                          (w_xlo >= LP_XLIM) | (w_ylo >= LP_YLIM);

    // Only meaningful when the box is not empty; then the clipped values fit
    // in WIDTH-1 unsigned bits because the resolution is at most 2^(WIDTH-1).
    assign w_cxmin = w_xlo[WIDTH] ? '0 : w_xlo[WIDTH-2:0];
    assign w_cymin = w_ylo[WIDTH] ? '0 : w_ylo[WIDTH-2:0];
    assign w_cxmax = (w_xhi >= LP_XLIM) ? LP_XLAST : w_xhi[WIDTH-2:0];
    assign w_cymax = (w_yhi >= LP_YLIM) ? LP_YLAST : w_yhi[WIDTH-2:0];

    // ---------------- next state ----------------
    always_comb begin
        w_next_state = r_state;
        w_x          = r_x;
        w_y          = r_y;
        w_xmin       = r_xmin;
        w_xmax       = r_xmax;
        w_ymax       = r_ymax;
        w_phase      = r_phase;
        w_ge         = r_ge;
        w_le         = r_le;
        w_adv        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tri_valid) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                if ((w_e == '0) || w_bbox_empty) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_xmin       = w_cxmin;
                    w_xmax       = w_cxmax;
                    w_ymax       = w_cymax;
                    w_x          = w_cxmin;
                    w_y          = w_cymin;
                    w_phase      = 2'd0;
                    w_next_state = ST_SCAN;
                end
            end
            ST_SCAN: begin
                case (r_phase)
                    2'd0: begin
                        w_ge[0] = w_e_ge;
                        w_le[0] = w_e_le;
                        w_phase = 2'd1;
                    end
                    2'd1: begin
                        w_ge[1] = w_e_ge;
                        w_le[1] = w_e_le;
                        w_phase = 2'd2;
                    end
                    default: begin
                        // Third edge is used straight from the evaluator.
                        if ((r_ge[0] & r_ge[1] & w_e_ge) | (r_le[0] & r_le[1] & w_e_le))
                            w_next_state = ST_EMIT;
                        else
                            w_adv = 1'b1;
                    end
                endcase
            end
            ST_EMIT: begin
                if (px_ready) w_adv = 1'b1;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_adv) begin
            w_phase = 2'd0;
            if (r_x < r_xmax) begin
                w_x          = r_x + 1'b1;
                w_next_state = ST_SCAN;
            end else if (r_y < r_ymax) begin
                w_x          = r_xmin;
                w_y          = r_y + 1'b1;
                w_next_state = ST_SCAN;
            end else begin
                w_next_state = ST_DONE;
            end
        end

        // Abort overrides everything, including a same-cycle pixel transfer.
        if (abort && (r_state != ST_IDLE)) w_next_state = ST_IDLE;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_v0        <= '0;
            r_v1        <= '0;
            r_v2        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_ymax      <= '0;
            r_phase     <= 2'd0;
            r_ge        <= 2'b00;
            r_le        <= 2'b00;
            r_tri_ready <= 1'b1;
            r_px_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && tri_valid) begin
                r_v0 <= v0;
                r_v1 <= v1;
                r_v2 <= v2;
            end
            r_x         <= w_x;
            r_y         <= w_y;
            r_xmin      <= w_xmin;
            r_xmax      <= w_xmax;
            r_ymax      <= w_ymax;
            r_phase     <= w_phase;
            r_ge        <= w_ge;
            r_le        <= w_le;
            // Status outputs are registered copies of the next-state decode.
            r_tri_ready <= (w_next_state == ST_IDLE);
            r_px_valid  <= (w_next_state == ST_EMIT);
            r_busy      <= (w_next_state != ST_IDLE);
            r_done      <= (w_next_state == ST_DONE);
        end
    end

    assign tri_ready = r_tri_ready;
    assign px_valid  = r_px_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign px_x      = r_x;
    assign px_y      = r_y;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tri_raster_ctrl
//   Self-checking bench for tri_raster_ctrl on a small 16x12 screen so that
//   right/bottom clipping is cheap to reach. A coverage model computes the
//   expected pixel list straight from the edge-function rules; a table holds
//   the directed cases, followed by abort/reset sequences and random triangles.
// -----------------------------------------------------------------------------
module tb_tri_raster_ctrl;
    import types_pkg::*;

    localparam int H_RES = 16;
    localparam int V_RES = 12;
    localparam int PW    = 2 * (WIDTH - 1);

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n;
    logic             tri_valid;
    logic             tri_ready;
    vector_t          v0, v1, v2;
    logic             abort;
    logic             px_valid;
    logic             px_ready;
    logic [WIDTH-2:0] px_x, px_y;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    tri_raster_ctrl #(.H_RES(H_RES), .V_RES(V_RES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tri_valid (tri_valid),
        .tri_ready (tri_ready),
        .v0        (v0),
        .v1        (v1),
        .v2        (v2),
        .abort     (abort),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_x      (px_x),
        .px_y      (px_y),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] obs_q[$];

    int tri10_x[10] = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    int tri10_y[10] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3};

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic vector_t mkv(input int x, input int y);
        vector_t v;
        v.x = WIDTH'(x);
        v.y = WIDTH'(y);
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic longint edge_fn(input int ax, input int ay, input int bx, input int by,
                                       input int qx, input int qy);
        return longint'(bx - ax) * longint'(qy - ay) - longint'(by - ay) * longint'(qx - ax);
    endfunction

    // Fills exp_q with covered pixels in raster order; nbbox is the number of
    // pixels the walker visits (0 when nothing is walked at all).
    task automatic model_tri(input int ax, input int ay, input int bx, input int by,
                             input int cx, input int cy, output int nbbox);
        longint area, e0, e1, e2;
        int xs, xe, ys, ye;
        exp_q.delete();
        nbbox = 0;
        area  = edge_fn(ax, ay, bx, by, cx, cy);
        xs = (ax < bx) ? ax : bx;  xs = (cx < xs) ? cx : xs;
        xe = (ax > bx) ? ax : bx;  xe = (cx > xe) ? cx : xe;
        ys = (ay < by) ? ay : by;  ys = (cy < ys) ? cy : ys;
        ye = (ay > by) ? ay : by;  ye = (cy > ye) ? cy : ye;
        if (xs < 0) xs = 0;
        if (ys < 0) ys = 0;
        if (xe > H_RES - 1) xe = H_RES - 1;
        if (ye > V_RES - 1) ye = V_RES - 1;
        if (area != 0 && xs <= xe && ys <= ye) begin
            for (int y = ys; y <= ye; y++) begin
                for (int x = xs; x <= xe; x++) begin
                    nbbox++;
                    e0 = edge_fn(ax, ay, bx, by, x, y);
                    e1 = edge_fn(bx, by, cx, cy, x, y);
                    e2 = edge_fn(cx, cy, ax, ay, x, y);
                    if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0))
                        exp_q.push_back({(WIDTH-1)'(x), (WIDTH-1)'(y)});
                end
            end
        end
    endtask

    // ---------------- driver / monitor ----------------
    // mode 0: px_ready always 1; 1: random; 2: first pixel stalled 10 cycles.
    // Cycle 0 is the handshake cycle; outputs are sampled 1 ns after each edge.
    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int mode,
                           output int first_cyc, output int done_cyc, output int ndone);
        int            cyc;
        int            stall;
        bit            prev_hold;
        bit            fin;
        logic [PW-1:0] prev_px;
        obs_q.delete();
        first_cyc = -1;
        done_cyc  = -1;
        ndone     = 0;
        stall     = 0;
        prev_hold = 1'b0;
        prev_px   = '0;
        fin       = 1'b0;
        cyc       = 0;
        check("idle_tri_ready", int'(tri_ready), 1);
        v0 = mkv(ax, ay);
        v1 = mkv(bx, by);
        v2 = mkv(cx, cy);
        tri_valid = 1'b1;
        px_ready  = 1'b0;
        while (!fin) begin
            @(posedge clk); #1;
            cyc++;
            tri_valid = 1'b0;
            if (prev_hold) begin
                check("hold_px_valid", int'(px_valid), 1);
                check("hold_px_xy", int'({px_x, px_y}), int'(prev_px));
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (px_valid && first_cyc < 0) first_cyc = cyc;
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = (stall >= 10);
            endcase
            if (px_valid && !px_ready) stall++;
            if (px_valid && px_ready) obs_q.push_back({px_x, px_y});
            prev_hold = px_valid && !px_ready;
            prev_px   = {px_x, px_y};
            if (done_cyc >= 0 && cyc == done_cyc + 1)
                check("tri_ready_after_done", int'(tri_ready), 1);
            if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1'b1;
            if (cyc >= 5000) fin = 1'b1;
        end
        px_ready = 1'b0;
        check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
    endtask

    // exp_first == -2 and exp_done == -1 / exp_npix == -1 mean "not given".
    task automatic run_and_check(input string tag, input int ax, input int ay, input int bx,
                                 input int by, input int cx, input int cy, input int mode,
                                 input int exp_npix, input int exp_first, input int exp_done,
                                 input bit chk_list);
        int            nbbox, ncov, first_cyc, done_cyc, ndone;
        logic [PW-1:0] e;
        logic [PW-1:0] o;
        model_tri(ax, ay, bx, by, cx, cy, nbbox);
        ncov = exp_q.size();
        run_tri(ax, ay, bx, by, cx, cy, mode, first_cyc, done_cyc, ndone);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_npix_model"}, obs_q.size(), ncov);
        if (exp_npix >= 0)  check({tag, "_npix"}, obs_q.size(), exp_npix);
        if (exp_first != -2) check({tag, "_first_valid_cyc"}, first_cyc, exp_first);
        if (exp_done >= 0)  check({tag, "_done_cyc"}, done_cyc, exp_done);
        else if (mode == 0) check({tag, "_done_cyc_model"}, done_cyc,
                                  (nbbox == 0) ? 2 : 2 + 3 * nbbox + ncov);
        if (chk_list) begin
            for (int i = 0; i < 10 && i < obs_q.size(); i++)
                check($sformatf("%s_list%0d", tag, i), int'(obs_q[i]),
                      int'({(WIDTH-1)'(tri10_x[i]), (WIDTH-1)'(tri10_y[i])}));
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check($sformatf("%s_pix", tag), int'(o), int'(e));
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string name;
        int    ax, ay, bx, by, cx, cy;
        int    mode;
        int    exp_npix;
        int    exp_first;
        int    exp_done;
        bit    chk_list;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    int cyc_a, nd_a, ax, ay, bx, by, cx, cy, mode;
    bit got_a;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"basic",     0,  0,  3,  0,  0,  3, 0, 10,  5,  60, 1'b1};
        vecs[1] = '{"reversed",  0,  0,  0,  3,  3,  0, 0, 10,  5,  60, 1'b1};
        vecs[2] = '{"collinear", 0,  0,  2,  2,  4,  4, 0,  0, -1,   2, 1'b0};
        vecs[3] = '{"clip_neg", -4, -4,  6, -4, -4,  6, 0,  6,  5, 155, 1'b0};
        vecs[4] = '{"backpress", 0,  0,  3,  0,  0,  3, 2, 10,  5,  70, 1'b1};
        vecs[5] = '{"offscr_neg", -10, -10, -5, -10, -10, -5, 0, 0, -1, 2, 1'b0};
        vecs[6] = '{"offscr_rt", 20,  2, 25,  2, 20,  8, 0,  0, -1,   2, 1'b0};
        vecs[7] = '{"corner",   15, 11, 20, 11, 15, 16, 0,  1,  5,   6, 1'b0};
        vecs[8] = '{"clip_pos", 10,  6, 22,  6, 10, 18, 0, 36,  5, 146, 1'b0};
        vecs[9] = '{"rand_rdy",  0,  0,  3,  0,  0,  3, 1, 10,  5,  -1, 1'b1};

        rst_n     = 1'b0;
        tri_valid = 1'b0;
        abort     = 1'b0;
        px_ready  = 1'b0;
        v0 = '0; v1 = '0; v2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tri_ready", int'(tri_ready), 1);
        check("rst_px_valid", int'(px_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_px_xy", int'({px_x, px_y}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int t = 0; t < NV; t++)
            run_and_check(vecs[t].name, vecs[t].ax, vecs[t].ay, vecs[t].bx, vecs[t].by,
                          vecs[t].cx, vecs[t].cy, vecs[t].mode, vecs[t].exp_npix,
                          vecs[t].exp_first, vecs[t].exp_done, vecs[t].chk_list);

        // Abort in EMIT with px_ready high in the same cycle.
        v0 = mkv(0, 0); v1 = mkv(3, 0); v2 = mkv(0, 3);
        tri_valid = 1'b1;
        cyc_a = 0;
        got_a = 1'b0;
        while (!got_a && cyc_a < 20) begin
            @(posedge clk); #1;
            cyc_a++;
            tri_valid = 1'b0;
            if (px_valid) got_a = 1'b1;
        end
        check("abort_first_valid_cyc", cyc_a, 5);
        abort    = 1'b1;
        px_ready = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        px_ready = 1'b0;
        check("abort_px_valid", int'(px_valid), 0);
        check("abort_tri_ready", int'(tri_ready), 1);
        check("abort_busy", int'(busy), 0);
        nd_a = int'(done);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) nd_a++;
        end
        check("abort_no_done", nd_a, 0);
        run_and_check("after_abort", 0, 0, 3, 0, 0, 3, 0, 10, 5, 60, 1'b1);

        // Asynchronous reset in the middle of SCAN.
        v0 = mkv(2, 3); v1 = mkv(6, 3); v2 = mkv(2, 7);
        tri_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tri_valid = 1'b0;
        end
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_px_x", int'(px_x), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tri_ready", int'(tri_ready), 1);
        check("arst_px_valid", int'(px_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_px_x", int'(px_x), 0);
        check("arst_px_y", int'(px_y), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tri_ready", int'(tri_ready), 1);
        run_and_check("after_reset", 2, 3, 6, 3, 2, 7, 0, -1, 5, -1, 1'b0);

        // Random triangles, partly off-screen, with random or always-on ready.
        for (int r = 0; r < 30; r++) begin
            ax = int'($urandom_range(0, 26)) - 6;
            ay = int'($urandom_range(0, 22)) - 6;
            bx = int'($urandom_range(0, 26)) - 6;
            by = int'($urandom_range(0, 22)) - 6;
            cx = int'($urandom_range(0, 26)) - 6;
            cy = int'($urandom_range(0, 22)) - 6;
            mode = int'($urandom_range(0, 1));
            run_and_check($sformatf("rand%0d", r), ax, ay, bx, by, cx, cy, mode,
                          -1, -2, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
